wr_ptr_ctrl: RTL and testbench

Write-domain pointer controller for the parameterised asynchronous FIFO, replacing the fixed-function write pointer logic. It synchronises the read-domain Gray pointer internally over a configurable number of stages and maintains binary and Gray write pointers. It also produces registered full and almost-full flags, with the almost-full threshold programmable at run time, plus a fill-level count and a sticky overflow flag. It sits between the write-side client, the dual-port RAM write port and the read-domain pointer controller.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/gray_to_binary.sv | 16 +
 rtl/ptr_sync.sv | 29 ++
 rtl/wr_ptr_ctrl.sv | 92 +++++++++
 tb/tb_wr_ptr_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width and Gray/binary conversion.
package fifo_pkg;

  localparam int SYNC_MIN = 2;

  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter.
module gray_to_binary
  import fifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [31:0] bin_w;

  assign bin_w = gray2bin(32'(gray_i));
  assign bin_o = bin_w[WIDTH-1:0];

endmodule

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer controller: pointers, full/almost-full,
// fill level and sticky overflow for the async FIFO.
module wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic                  ovf_clr,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_mem_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_WIDTH);

  logic [PW-1:0] rd_gray_s, rd_bin_s;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          acc;
  logic [31:0]   gray_w;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk (wr_clk),
    .rst (wr_rst),
    .d_i (rd_ptr_gray),
    .q_o (rd_gray_s)
  );

  gray_to_binary #(
    .WIDTH (PW)
  ) u_rd_g2b (
    .gray_i (rd_gray_s),
    .bin_o  (rd_bin_s)
  );

  assign acc    = wr_en & ~full_q;
  assign wptr_d = wptr_q + PW'(acc);
  assign gray_w = bin2gray(32'(wptr_d));
  assign gray_d = gray_w[PW-1:0];

  // Level uses the lagging synced read pointer, so it never under-reports.
  assign level_d = wptr_d - rd_bin_s;
  assign full_d  = (level_d == DEPTH);
  assign af_d    = (level_d >= af_thresh);
  assign ovf_d   = (wr_en & full_q) | (ovf_q & ~ovf_clr);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wptr_q  <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_ptr_gray = gray_q;
  assign wr_addr     = wptr_q[ADDR_WIDTH-1:0];
  assign wr_mem_en   = acc;
  assign full        = full_q;
  // A zero threshold holds almost_full high, including through reset.
  assign almost_full = af_q | ~|af_thresh;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Self-checking bench for wr_ptr_ctrl: directed table plus
// randomized traffic against a pointer-arithmetic reference model.
module tb_wr_ptr_ctrl;

  localparam int AW = 4;
  localparam int SS = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MOD = 2 * DEPTH;

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW:0]   af_thresh = '0;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   rd_ptr_gray = '0;
  logic [AW:0]   wr_ptr_gray;
  logic [AW-1:0] wr_addr;
  logic          wr_mem_en;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  wr_ptr_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (SS)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .wr_en       (wr_en),
    .af_thresh   (af_thresh),
    .ovf_clr     (ovf_clr),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_ptr_gray (wr_ptr_gray),
    .wr_addr     (wr_addr),
    .wr_mem_en   (wr_mem_en),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: total counts and a queue of read pointers in flight.
  int m_wtot, m_lvl;
  bit m_full, m_af, m_ovf;
  int sq[$];
  logic [AW:0] prev_gray;

  typedef struct {
    bit wr; bit clr; int rd;
    int lvl; bit full; bit af; bit ovf; int addr; bit mem;
  } vec_t;
  vec_t tbl[27];

  function automatic int gray(input int x);
    return (x % MOD) ^ ((x % MOD) >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wtot = 0; m_lvl = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    sq.delete();
    for (int i = 0; i < SS; i++) sq.push_back(0);
    prev_gray = '0;
  endtask

  task automatic do_reset();
    wr_rst = 1'b1;
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    rd_ptr_gray = '0;
    model_reset();
    @(posedge wr_clk);
    @(negedge wr_clk);
    wr_rst = 1'b0;
  endtask

  task automatic step(input bit wr, input bit clr, input int rd, input bit mchk);
    int rs;
    bit acc;
    wr_en = wr;
    ovf_clr = clr;
    rd_ptr_gray = (AW+1)'(gray(rd));
    #1;
    if (mchk) chk("mem_en", wr_mem_en, wr && !m_full);
    @(posedge wr_clk);
    acc = wr && !m_full;
    m_ovf = (wr && m_full) || (m_ovf && !clr);
    if (acc) m_wtot++;
    rs = sq.pop_front();
    sq.push_back(rd % MOD);
    m_lvl = ((m_wtot % MOD) - rs + MOD) % MOD;
    m_full = (m_lvl == DEPTH);
    m_af = (m_lvl >= int'(af_thresh));
    #1;
    if (mchk) begin
      chk("level", wr_level, m_lvl);
      chk("full", full, m_full);
      chk("almost_full", almost_full, m_af || af_thresh == 0);
      chk("overflow", overflow, m_ovf);
      chk("wr_addr", wr_addr, m_wtot % DEPTH);
      chk("wr_ptr_gray", wr_ptr_gray, gray(m_wtot));
      chk("gray_step", $countones(wr_ptr_gray ^ prev_gray) <= 1, 1);
    end
    prev_gray = wr_ptr_gray;
  endtask

  initial begin
    int rtot, thr;
    bit saw_af;

    for (int i = 0; i < 16; i++)
      tbl[i] = '{1, 0, 0, i + 1, i == 15, i + 1 >= 12, 0, (i + 1) % 16, 1};
    tbl[16] = '{1, 0, 0, 16, 1, 1, 1, 0, 0};
    tbl[17] = '{0, 1, 0, 16, 1, 1, 0, 0, 0};
    tbl[18] = '{1, 0, 0, 16, 1, 1, 1, 0, 0};
    tbl[19] = '{1, 1, 0, 16, 1, 1, 1, 0, 0};
    tbl[20] = '{0, 1, 4, 16, 1, 1, 0, 0, 0};
    tbl[21] = '{0, 0, 4, 16, 1, 1, 0, 0, 0};
    tbl[22] = '{0, 0, 4, 12, 0, 1, 0, 0, 0};
    tbl[23] = '{1, 0, 4, 13, 0, 1, 0, 1, 1};
    tbl[24] = '{0, 0, 6, 13, 0, 1, 0, 1, 0};
    tbl[25] = '{0, 0, 6, 13, 0, 1, 0, 1, 0};
    tbl[26] = '{0, 0, 6, 11, 0, 0, 0, 1, 0};

    // Directed table: fill, overflow handling, read arrival, af threshold.
    af_thresh = 5'd12;
    do_reset();
    #1;
    chk("rst_level", wr_level, 0);
    chk("rst_full", full, 0);
    chk("rst_gray", wr_ptr_gray, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_af", almost_full, 0);
    for (int i = 0; i < 27; i++) begin
      wr_en = tbl[i].wr;
      #1;
      chk($sformatf("tbl%0d_mem", i), wr_mem_en, int'(tbl[i].mem));
      step(tbl[i].wr, tbl[i].clr, tbl[i].rd, 1'b0);
      chk($sformatf("tbl%0d_level", i), wr_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_full", i), full, int'(tbl[i].full));
      chk($sformatf("tbl%0d_af", i), almost_full, int'(tbl[i].af));
      chk($sformatf("tbl%0d_ovf", i), overflow, int'(tbl[i].ovf));
      chk($sformatf("tbl%0d_addr", i), wr_addr, tbl[i].addr);
      if (i == 15) chk("gray_after_16", wr_ptr_gray, 5'b11000);
    end

    // Zero threshold holds almost_full high from reset.
    af_thresh = 5'd0;
    wr_rst = 1'b1;
    #1;
    chk("af_thr0_in_rst", almost_full, 1);
    do_reset();
    #1;
    chk("af_thr0_after_rst", almost_full, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 1'b1);

    // Threshold above depth: almost_full never asserts.
    af_thresh = 5'd17;
    do_reset();
    saw_af = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 0, 1'b1);
      if (almost_full) saw_af = 1;
    end
    chk("af_thr17_never", saw_af, 0);

    // Wrap: 40 write cycles with the reader trailing close behind.
    af_thresh = 5'd12;
    do_reset();
    rtot = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, rtot, 1'b1);
      if (m_wtot > 3) rtot = m_wtot - 3;
    end
    chk("wrap_passed", m_wtot >= MOD, 1);

    // Asynchronous reset mid-burst at level 9.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 0, 1'b1);
    chk("pre_rst_level9", wr_level, 9);
    #2;
    wr_rst = 1'b1;
    wr_en = 1'b1;
    #1;
    chk("arst_level", wr_level, 0);
    chk("arst_addr", wr_addr, 0);
    chk("arst_gray", wr_ptr_gray, 0);
    chk("arst_full", full, 0);
    chk("arst_af", almost_full, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_mem_en", wr_mem_en, 1);
    model_reset();
    @(negedge wr_clk);
    wr_rst = 1'b0;
    #1;
    chk("first_addr_after_rst", wr_addr, 0);
    step(1'b1, 1'b0, 0, 1'b1);
    chk("second_addr_after_rst", wr_addr, 1);

    // Randomized traffic with a lagging, legal read pointer.
    do_reset();
    rtot = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) begin
        thr = $urandom_range(0, 17);
        af_thresh = (AW+1)'(thr);
      end
      step($urandom_range(0, 99) < 65, $urandom_range(0, 9) == 0, rtot, 1'b1);
      if (rtot < m_wtot && $urandom_range(0, 99) < 45) rtot++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
